call_register: RTL and testbench

Clocked, parametrised elevator call register: it latches in-car and landing (up/down) call buttons into per-floor request bits and clears them when the controller reports a floor as serviced. Raw button inputs are synchronised and edge-detected. The block also provides direction-summary flags and a pending-call count. It sits between the button panels and the elevator controller FSM, replacing the unclocked latch stage.

---
 rtl/elevator_pkg.sv | 18 +
 rtl/btn_sync_edge.sv | 36 +++
 rtl/call_register.sv | 150 +++++++++++++++
 tb/tb_call_register.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: service-direction encodings and width helpers.
package elevator_pkg;

  localparam logic [1:0] SVC_IN   = 2'b00;
  localparam logic [1:0] SVC_UP   = 2'b01;
  localparam logic [1:0] SVC_DN   = 2'b10;
  localparam logic [1:0] SVC_BOTH = 2'b11;

  function automatic int floor_w(input int floors);
    return $clog2(floors);
  endfunction

  // Wide enough for every in-car, up and down request bit at once.
  function automatic int pop_w(input int floors);
    return $clog2(3 * floors - 1);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Per-bit synchroniser followed by a registered rising-edge detector.
// Latency: raw rise sampled at edge N gives a one-cycle pulse after edge N+STAGES.
module btn_sync_edge #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] rise_o
);

  logic [STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]             prev_q;
  logic [W-1:0]             rise_q;
  logic [STAGES:0]          fill_q;

  // fill_q masks edges until the chain and prev_q hold real samples, so a
  // button already held when reset releases never looks like a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      prev_q <= sync_q[STAGES-1];
      fill_q <= {fill_q[STAGES-1:0], 1'b1};
      rise_q <= fill_q[STAGES] ? (sync_q[STAGES-1] & ~prev_q) : '0;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/call_register.sv
// Elevator call register: latches synchronised button edges into request bits, clears on service.
// Optional in-car call cancellation by re-press is built when CALL_CANCEL_EN is defined.
module call_register
  import elevator_pkg::*;
#(
  parameter int  FLOORS        = 8,
  parameter int  SYNC_STAGES   = 2,
  parameter int  CANCEL_WINDOW = 16,
  localparam int FW            = floor_w(FLOORS),
  localparam int PW            = pop_w(FLOORS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] btn_in,
  input  logic [FLOORS-2:0] btn_up_out,
  input  logic [FLOORS-1:1] btn_down_out,
  input  logic              svc_valid,
  input  logic [FW-1:0]     svc_floor,
  input  logic [1:0]        svc_dir,
  input  logic [FW-1:0]     car_floor,
  output logic [FLOORS-1:0] active_in_levels,
  output logic [FLOORS-2:0] active_out_up_levels,
  output logic [FLOORS-1:1] active_out_down_levels,
  output logic              req_above,
  output logic              req_below,
  output logic              req_here,
  output logic [PW-1:0]     pending_count,
  output logic              svc_ack
);

  localparam logic [FW:0] FLOORS_L = (FW+1)'(FLOORS);

  logic [FLOORS-1:0] in_edge, in_q, in_d, clr_in, any_req;
  logic [FLOORS-2:0] up_edge, up_q, up_d, clr_up;
  logic [FLOORS-2:0] dn_rise;
  logic [FLOORS-1:1] dn_edge, dn_q, dn_d, clr_dn;
  logic [PW-1:0]     count_q, count_d;
  logic              svc_hit, ack_q;

  btn_sync_edge #(.W(FLOORS), .STAGES(SYNC_STAGES)) u_sync_in (
    .clk(clk), .reset(reset), .din_i(btn_in), .rise_o(in_edge)
  );
  btn_sync_edge #(.W(FLOORS-1), .STAGES(SYNC_STAGES)) u_sync_up (
    .clk(clk), .reset(reset), .din_i(btn_up_out), .rise_o(up_edge)
  );
  btn_sync_edge #(.W(FLOORS-1), .STAGES(SYNC_STAGES)) u_sync_dn (
    .clk(clk), .reset(reset), .din_i(btn_down_out), .rise_o(dn_rise)
  );
  assign dn_edge = dn_rise;

  // Landing bits that have no physical button are never cleared (or set).
  always_comb begin
    svc_hit = svc_valid && ({1'b0, svc_floor} < FLOORS_L);
    clr_in  = '0;
    clr_up  = '0;
    clr_dn  = '0;
    for (int i = 0; i < FLOORS; i++)
      clr_in[i] = svc_hit && (svc_floor == FW'(i));
    for (int i = 0; i < FLOORS-1; i++)
      clr_up[i] = clr_in[i] && |(svc_dir & SVC_UP);
    for (int i = 1; i < FLOORS; i++)
      clr_dn[i] = clr_in[i] && |(svc_dir & SVC_DN);
    up_d = (up_q & ~clr_up) | up_edge;
    dn_d = (dn_q & ~clr_dn) | dn_edge;
  end

`ifdef CALL_CANCEL_EN
  localparam int CW = $clog2(CANCEL_WINDOW + 1);

  logic [FLOORS-1:0][CW-1:0] win_q, win_d;
  logic [FLOORS-1:0]         cancel;

  // A re-press inside the window drops the call; it overrides both set and clear.
  always_comb begin
    in_d   = '0;
    win_d  = '0;
    cancel = '0;
    for (int i = 0; i < FLOORS; i++) begin
      cancel[i] = in_edge[i] && in_q[i] && (win_q[i] != '0);
      in_d[i]   = !cancel[i] && ((in_q[i] && !clr_in[i]) || in_edge[i]);
      if (!in_d[i])
        win_d[i] = '0;
      else if (in_edge[i] && (!in_q[i] || clr_in[i]))
        win_d[i] = CW'(CANCEL_WINDOW);
      else if (win_q[i] != '0)
        win_d[i] = win_q[i] - CW'(1);
      else
        win_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) win_q <= '0;
    else        win_q <= win_d;
  end
`else
  always_comb begin
    in_d = (in_q & ~clr_in) | in_edge;
  end
`endif

  // Counted from next-state so the count lands on the same edge as the bits.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < FLOORS; i++)
      count_d = count_d + PW'(in_d[i]);
    for (int i = 0; i < FLOORS-1; i++)
      count_d = count_d + PW'(up_d[i]);
    for (int i = 1; i < FLOORS; i++)
      count_d = count_d + PW'(dn_d[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q    <= '0;
      up_q    <= '0;
      dn_q    <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      in_q    <= in_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      count_q <= count_d;
      ack_q   <= svc_hit;
    end
  end

  assign any_req = in_q | {1'b0, up_q} | {dn_q, 1'b0};

  always_comb begin
    req_above = 1'b0;
    req_below = 1'b0;
    req_here  = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (any_req[i]) begin
        if (FW'(i) > car_floor)  req_above = 1'b1;
        if (FW'(i) < car_floor)  req_below = 1'b1;
        if (FW'(i) == car_floor) req_here  = 1'b1;
      end
    end
  end

  assign active_in_levels       = in_q;
  assign active_out_up_levels   = up_q;
  assign active_out_down_levels = dn_q;
  assign pending_count          = count_q;
  assign svc_ack                = ack_q;

endmodule

// File: tb/tb_call_register.sv
// Directed, table-driven bench for call_register (FLOORS=8) plus a FLOORS=5 instance for out-of-range service.
module tb_call_register;

`ifdef CALL_CANCEL_EN
  localparam bit C = 1'b1;
`else
  localparam bit C = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main instance, FLOORS=8
  logic [7:0] btn_in, act_in;
  logic [6:0] btn_up, act_up;
  logic [7:1] btn_dn, act_dn;
  logic       svc_valid, svc_ack, req_above, req_below, req_here;
  logic [2:0] svc_floor, car_floor;
  logic [1:0] svc_dir;
  logic [4:0] pend;

  call_register #(.FLOORS(8), .SYNC_STAGES(2), .CANCEL_WINDOW(16)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_up_out(btn_up), .btn_down_out(btn_dn),
    .svc_valid(svc_valid), .svc_floor(svc_floor), .svc_dir(svc_dir), .car_floor(car_floor),
    .active_in_levels(act_in), .active_out_up_levels(act_up), .active_out_down_levels(act_dn),
    .req_above(req_above), .req_below(req_below), .req_here(req_here),
    .pending_count(pend), .svc_ack(svc_ack)
  );

  // Second instance, FLOORS=5, so a 3-bit svc_floor can name a floor that does not exist
  logic [4:0] b_btn_in, b_act_in;
  logic [3:0] b_btn_up, b_act_up;
  logic [4:1] b_btn_dn, b_act_dn;
  logic       b_svc_valid, b_svc_ack, b_above, b_below, b_here;
  logic [2:0] b_svc_floor, b_car_floor;
  logic [1:0] b_svc_dir;
  logic [3:0] b_pend;

  call_register #(.FLOORS(5), .SYNC_STAGES(2), .CANCEL_WINDOW(16)) dut_b (
    .clk(clk), .reset(reset), .btn_in(b_btn_in), .btn_up_out(b_btn_up), .btn_down_out(b_btn_dn),
    .svc_valid(b_svc_valid), .svc_floor(b_svc_floor), .svc_dir(b_svc_dir), .car_floor(b_car_floor),
    .active_in_levels(b_act_in), .active_out_up_levels(b_act_up), .active_out_down_levels(b_act_dn),
    .req_above(b_above), .req_below(b_below), .req_here(b_here),
    .pending_count(b_pend), .svc_ack(b_svc_ack)
  );

  typedef struct {
    logic [7:0] bi;
    logic [6:0] bu;
    logic [7:1] bd;
    logic       sv;
    logic [2:0] sf;
    logic [1:0] sd;
    logic [2:0] cf;
    int         cyc;
    logic [7:0] ein;
    logic [6:0] eup;
    logic [7:1] edn;
    logic [2:0] flg;  // {above, below, here}
    logic [4:0] ecnt;
    logic       eack;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] bi, input logic [6:0] bu, input logic [7:1] bd,
                     input logic sv, input logic [2:0] sf, input logic [1:0] sd,
                     input logic [2:0] cf, input int cyc,
                     input logic [7:0] ein, input logic [6:0] eup, input logic [7:1] edn,
                     input logic [2:0] flg, input logic [4:0] ecnt, input logic eack);
    vec_t v;
    v.bi = bi; v.bu = bu; v.bd = bd; v.sv = sv; v.sf = sf; v.sd = sd; v.cf = cf; v.cyc = cyc;
    v.ein = ein; v.eup = eup; v.edn = edn; v.flg = flg; v.ecnt = ecnt; v.eack = eack;
    tbl.push_back(v);
  endtask

  initial begin
    // Single-cycle press of floor 3, visible three edges after it is sampled
    add(8'h00, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd0,  1, 8'h00, 7'h00, 7'h00, 3'b000, 5'd0, 0);
    add(8'h08, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd1,  1, 8'h00, 7'h00, 7'h00, 3'b000, 5'd0, 0);
    add(8'h00, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd1,  2, 8'h00, 7'h00, 7'h00, 3'b000, 5'd0, 0);
    add(8'h00, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd1,  1, 8'h08, 7'h00, 7'h00, 3'b100, 5'd1, 0);
    add(8'h00, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd3,  1, 8'h08, 7'h00, 7'h00, 3'b001, 5'd1, 0);
    add(8'h00, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5,  1, 8'h08, 7'h00, 7'h00, 3'b010, 5'd1, 0);
    // Held up button sets once; service floor 0 up clears it
    add(8'h00, 7'h01, 7'h00, 0, 3'd0, 2'b00, 3'd5, 20, 8'h08, 7'h01, 7'h00, 3'b010, 5'd2, 0);
    add(8'h00, 7'h01, 7'h00, 1, 3'd0, 2'b01, 3'd5,  1, 8'h08, 7'h00, 7'h00, 3'b010, 5'd1, 1);
    add(8'h00, 7'h01, 7'h00, 0, 3'd0, 2'b00, 3'd5,  1, 8'h08, 7'h00, 7'h00, 3'b010, 5'd1, 0);
    // Top floor: in + down set, service with both directions
    add(8'h80, 7'h00, 7'h40, 0, 3'd0, 2'b00, 3'd5,  4, 8'h88, 7'h00, 7'h40, 3'b110, 5'd3, 0);
    add(8'h00, 7'h00, 7'h00, 1, 3'd7, 2'b11, 3'd5,  1, 8'h08, 7'h00, 7'h00, 3'b010, 5'd1, 1);
    add(8'h00, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5,  1, 8'h08, 7'h00, 7'h00, 3'b010, 5'd1, 0);
    add(8'h00, 7'h00, 7'h00, 1, 3'd3, 2'b00, 3'd5,  1, 8'h00, 7'h00, 7'h00, 3'b000, 5'd0, 1);
    add(8'h00, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5,  1, 8'h00, 7'h00, 7'h00, 3'b000, 5'd0, 0);
    // Set edge and service clear on the same bit in the same cycle: set wins
    add(8'h04, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5,  3, 8'h00, 7'h00, 7'h00, 3'b000, 5'd0, 0);
    add(8'h04, 7'h00, 7'h00, 1, 3'd2, 2'b00, 3'd5,  1, 8'h04, 7'h00, 7'h00, 3'b010, 5'd1, 1);
    add(8'h04, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5,  1, 8'h04, 7'h00, 7'h00, 3'b010, 5'd1, 0);
    add(8'h00, 7'h00, 7'h00, 1, 3'd2, 2'b00, 3'd5,  1, 8'h00, 7'h00, 7'h00, 3'b000, 5'd0, 1);
    add(8'h00, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5,  1, 8'h00, 7'h00, 7'h00, 3'b000, 5'd0, 0);
    // Re-press of floor 5: 10 cycles after set (cancels if enabled), then 20 cycles after set
    add(8'h20, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5,  4, 8'h20, 7'h00, 7'h00, 3'b001, 5'd1, 0);
    add(8'h00, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5,  6, 8'h20, 7'h00, 7'h00, 3'b001, 5'd1, 0);
    add(8'h20, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5,  4, C ? 8'h00 : 8'h20, 7'h00, 7'h00,
        C ? 3'b000 : 3'b001, C ? 5'd0 : 5'd1, 0);
    add(8'h00, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5,  2, C ? 8'h00 : 8'h20, 7'h00, 7'h00,
        C ? 3'b000 : 3'b001, C ? 5'd0 : 5'd1, 0);
    add(8'h20, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5,  4, 8'h20, 7'h00, 7'h00, 3'b001, 5'd1, 0);
    add(8'h00, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5, 16, 8'h20, 7'h00, 7'h00, 3'b001, 5'd1, 0);
    add(8'h20, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5,  4, 8'h20, 7'h00, 7'h00, 3'b001, 5'd1, 0);
    add(8'h00, 7'h00, 7'h00, 1, 3'd5, 2'b00, 3'd5,  1, 8'h00, 7'h00, 7'h00, 3'b000, 5'd0, 1);
    add(8'h00, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5,  1, 8'h00, 7'h00, 7'h00, 3'b000, 5'd0, 0);
    // Mid floor with both landing calls: each direction clears independently
    add(8'h00, 7'h10, 7'h08, 0, 3'd0, 2'b00, 3'd5,  4, 8'h00, 7'h10, 7'h08, 3'b010, 5'd2, 0);
    add(8'h00, 7'h00, 7'h00, 1, 3'd4, 2'b01, 3'd5,  1, 8'h00, 7'h00, 7'h08, 3'b010, 5'd1, 1);
    add(8'h00, 7'h00, 7'h00, 1, 3'd4, 2'b10, 3'd5,  1, 8'h00, 7'h00, 7'h00, 3'b000, 5'd0, 1);
    add(8'h00, 7'h00, 7'h00, 0, 3'd0, 2'b00, 3'd5,  1, 8'h00, 7'h00, 7'h00, 3'b000, 5'd0, 0);

    reset = 1'b0;
    btn_in = '0; btn_up = '0; btn_dn = '0;
    svc_valid = 1'b0; svc_floor = '0; svc_dir = '0; car_floor = '0;
    b_btn_in = '0; b_btn_up = '0; b_btn_dn = '0;
    b_svc_valid = 1'b0; b_svc_floor = '0; b_svc_dir = '0; b_car_floor = '0;
    repeat (3) tick();
    check("reset in", act_in, 8'h00);
    check("reset pend", pend, 5'd0);
    check("reset ack", svc_ack, 1'b0);
    check("reset flags", {req_above, req_below, req_here}, 3'b000);
    reset = 1'b1;
    repeat (5) tick();

    foreach (tbl[i]) begin
      btn_in = tbl[i].bi; btn_up = tbl[i].bu; btn_dn = tbl[i].bd;
      svc_valid = tbl[i].sv; svc_floor = tbl[i].sf; svc_dir = tbl[i].sd;
      car_floor = tbl[i].cf;
      repeat (tbl[i].cyc) tick();
      check($sformatf("row%0d in", i), act_in, tbl[i].ein);
      check($sformatf("row%0d up", i), act_up, tbl[i].eup);
      check($sformatf("row%0d dn", i), act_dn, tbl[i].edn);
      check($sformatf("row%0d flags", i), {req_above, req_below, req_here}, tbl[i].flg);
      check($sformatf("row%0d pend", i), pend, tbl[i].ecnt);
      check($sformatf("row%0d ack", i), svc_ack, tbl[i].eack);
    end

    // Six pending calls, then asynchronous reset between clock edges
    btn_in = 8'h3F;
    repeat (4) tick();
    check("six in", act_in, 8'h3F);
    check("six pend", pend, 5'd6);
    #2;
    reset = 1'b0;
    btn_in = 8'h01;
    #1;
    check("async rst in", act_in, 8'h00);
    check("async rst pend", pend, 5'd0);
    check("async rst flags", {req_above, req_below, req_here}, 3'b000);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) tick();
    check("held over reset in", act_in, 8'h00);
    check("held over reset pend", pend, 5'd0);
    btn_in = 8'h00;

    // FLOORS=5: floor 7 and floor 5 do not exist, floor 4 does
    b_btn_in = 5'h10;
    repeat (4) tick();
    check("b set in", b_act_in, 5'h10);
    b_btn_in = 5'h00;
    b_svc_valid = 1'b1; b_svc_floor = 3'd7; b_svc_dir = 2'b11;
    tick();
    check("b oor7 in", b_act_in, 5'h10);
    check("b oor7 ack", b_svc_ack, 1'b0);
    b_svc_floor = 3'd5;
    tick();
    check("b oor5 in", b_act_in, 5'h10);
    check("b oor5 ack", b_svc_ack, 1'b0);
    check("b oor5 pend", b_pend, 4'd1);
    b_svc_floor = 3'd4;
    tick();
    check("b svc4 in", b_act_in, 5'h00);
    check("b svc4 ack", b_svc_ack, 1'b1);
    b_svc_valid = 1'b0;
    tick();
    check("b ack drop", b_svc_ack, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
